// File: rtl/decipher.sv
// RC5-style block decryptor: r inverse rounds followed by key un-whitening.
// Reads S[2i] and S[2i+1] through the shared dual-word key port.
// Optional feature macro: DECIPHER_ROT_EN (data-dependent rotations).
module decipher #(
  parameter int unsigned r = 12,
  parameter int unsigned t = 26,
  parameter int unsigned w = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [w-1:0]         A,
  input  logic [w-1:0]         B,
  input  logic [w-1:0]         S_sub_i1,
  input  logic [w-1:0]         S_sub_i2,
  output logic [$clog2(t)-1:0] S_address,
  output logic                 busy,
  output logic                 done,
  output logic [w-1:0]         A_plain,
  output logic [w-1:0]         B_plain
);

  localparam int unsigned t_length = $clog2(t);
  // Counter must hold the value r itself, so size for r+1 values.
  localparam int unsigned r_length = $clog2(r + 1);
`ifdef DECIPHER_ROT_EN
  localparam int unsigned lgw = $clog2(w);

  // Rotate right by the low lgw bits; {x,x} makes a shift of 0 the identity.
  function automatic logic [w-1:0] rotr(input logic [w-1:0] x, input logic [lgw-1:0] n);
    logic [2*w-1:0] d;
    d = {x, x} >> n;
    return d[w-1:0];
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [r_length-1:0] r_i;
  logic [w-1:0]        r_a;
  logic [w-1:0]        r_b;
  logic [w-1:0]        w_diff_a;
  logic [w-1:0]        w_diff_b;
  logic [w-1:0]        w_an;
  logic [w-1:0]        w_bn;
  logic                w_last_round;

  assign w_last_round = (r_i == r_length'(1));

  // One inverse round; in FINAL the same subtractors do the un-whitening (S address is 0).
  assign w_diff_b = r_b - S_sub_i2;
  assign w_diff_a = r_a - S_sub_i1;
`ifdef DECIPHER_ROT_EN
  assign w_bn = rotr(w_diff_b, r_a[lgw-1:0]) ^ r_a;
  assign w_an = rotr(w_diff_a, w_bn[lgw-1:0]) ^ w_bn;
`else
  assign w_bn = w_diff_b ^ r_a;
  assign w_an = w_diff_a ^ w_bn;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; start is honoured only in IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = ROUND;
      ROUND:   if (w_last_round) w_state_next = FINAL;
      FINAL:   w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath, round counter, key address and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      S_address <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      A_plain   <= '0;
      B_plain   <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a       <= A;
            r_b       <= B;
            r_i       <= r_length'(r);
            busy      <= 1'b1;
            S_address <= t_length'(2 * r);
          end
        end
        ROUND: begin
          r_a <= w_an;
          r_b <= w_bn;
          r_i <= r_i - r_length'(1);
          if (w_last_round) S_address <= '0;
          else              S_address <= t_length'(2 * (32'(r_i) - 32'd1));
        end
        FINAL: begin
          A_plain <= w_diff_a;
          B_plain <= w_diff_b;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        DONE: begin
          S_address <= '0;
        end
        default: begin
          S_address <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decipher.sv
// Directed bench for decipher: a 12-round instance and a 1-round instance.
module tb_decipher;

`ifdef DECIPHER_ROT_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start12, start1;
  logic [31:0] a12, b12, a1, b1;
  logic [31:0] s12 [0:25];
  logic [31:0] s1  [0:3];
  logic [4:0]  addr12;
  logic [1:0]  addr1;
  logic [31:0] si1_12, si2_12, si1_1, si2_1;
  logic        busy12, done12, busy1, done1;
  logic [31:0] ap12, bp12, ap1, bp1;

  assign si1_12 = s12[addr12];
  assign si2_12 = s12[addr12 + 5'd1];
  assign si1_1  = s1[addr1];
  assign si2_1  = s1[addr1 + 2'd1];

  decipher #(.r(12), .t(26), .w(32)) u_d12 (
    .clk(clk), .rst(rst), .start(start12), .A(a12), .B(b12),
    .S_sub_i1(si1_12), .S_sub_i2(si2_12), .S_address(addr12),
    .busy(busy12), .done(done12), .A_plain(ap12), .B_plain(bp12));

  decipher #(.r(1), .t(4), .w(32)) u_d1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
    .S_sub_i1(si1_1), .S_sub_i2(si2_1), .S_address(addr1),
    .busy(busy1), .done(done1), .A_plain(ap1), .B_plain(bp1));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] d;
    d = {x, x} << n;
    return d[63:32];
  endfunction

  function automatic logic [31:0] erot(input logic [31:0] x, input logic [4:0] n);
    return ROT_EN ? rotl(x, n) : x;
  endfunction

  // Forward cipher model over s12, used to make ciphertexts.
  task automatic enc12(input logic [31:0] pa, input logic [31:0] pb,
                       output logic [31:0] ca, output logic [31:0] cb);
    logic [31:0] x, y;
    x = pa + s12[0];
    y = pb + s12[1];
    for (int i = 1; i <= 12; i++) begin
      x = erot(x ^ y, y[4:0]) + s12[2*i];
      y = erot(y ^ x, x[4:0]) + s12[2*i+1];
    end
    ca = x;
    cb = y;
  endtask

  // RC5-32/12/16 key expansion for the all-zero 16-byte key.
  task automatic keyexp_zero();
    logic [31:0] l [0:3];
    logic [31:0] ka, kb, tmp;
    int i, j;
    s12[0] = 32'hB7E15163;
    for (int k = 1; k < 26; k++) s12[k] = s12[k-1] + 32'h9E3779B9;
    for (int k = 0; k < 4; k++) l[k] = 32'h0;
    ka = 0; kb = 0; i = 0; j = 0;
    for (int k = 0; k < 78; k++) begin
      ka = rotl(s12[i] + ka + kb, 5'd3);
      s12[i] = ka;
      tmp = ka + kb;
      kb = rotl(l[j] + tmp, tmp[4:0]);
      l[j] = kb;
      i = (i + 1) % 26;
      j = (j + 1) % 4;
    end
  endtask

  int          cyc;
  bit          seen_done;
  logic [31:0] ca, cb, pa, pb, exp_a, exp_b;

  initial begin
    rst = 1'b1; start12 = 1'b0; start1 = 1'b0;
    a12 = 0; b12 = 0; a1 = 0; b1 = 0;
    for (int k = 0; k < 4; k++) s1[k] = 32'h0;
    keyexp_zero();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_addr", 32'(addr12), 32'd0);
    chk("rst_busy", 32'(busy12), 32'd0);
    chk("rst_done", 32'(done12), 32'd0);
    chk("rst_ap",   ap12, 32'd0);
    chk("rst_bp",   bp12, 32'd0);
    rst = 1'b0;

    // Reset held 3 cycles mid-ROUND aborts without done
    a12 = 32'h1111_2222; b12 = 32'h3333_4444; start12 = 1'b1;
    @(negedge clk); start12 = 1'b0;
    repeat (4) @(negedge clk);
    chk("t1_busy_pre", 32'(busy12), 32'd1);
    rst = 1'b1; seen_done = 1'b0;
    repeat (3) begin @(negedge clk); seen_done |= done12; end
    chk("t1_addr", 32'(addr12), 32'd0);
    chk("t1_busy", 32'(busy12), 32'd0);
    chk("t1_done", 32'(done12), 32'd0);
    chk("t1_ap",   ap12, 32'd0);
    chk("t1_bp",   bp12, 32'd0);
    rst = 1'b0;
    repeat (20) begin @(negedge clk); seen_done |= done12; end
    chk("t1_no_done", 32'(seen_done), 32'd0);

    // Known vector, address sequence, ignored start pulses in ROUND and DONE
`ifdef DECIPHER_ROT_EN
    ca = 32'hEEDBA521; cb = 32'h6D8F4B15;
`else
    enc12(32'h0, 32'h0, ca, cb);
`endif
    a12 = ca; b12 = cb; start12 = 1'b1;
    @(negedge clk);
    start12 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      chk($sformatf("t2_addr_c%0d", k), 32'(addr12), 32'(2 * (13 - k)));
      chk($sformatf("t2_busy_c%0d", k), 32'(busy12), 32'd1);
      if (k == 4) begin start12 = 1'b1; a12 = 32'hDEAD_BEEF; end
      if (k == 5) start12 = 1'b0;
      @(negedge clk);
    end
    chk("t2_final_addr", 32'(addr12), 32'd0);
    chk("t2_final_done", 32'(done12), 32'd0);
    @(negedge clk);
    chk("t2_done_c14", 32'(done12), 32'd1);
    chk("t2_busy_c14", 32'(busy12), 32'd0);
    chk("t2_ap", ap12, 32'd0);
    chk("t2_bp", bp12, 32'd0);
    start12 = 1'b1;
    @(negedge clk);
    start12 = 1'b0;
    chk("t2_done_1cyc", 32'(done12), 32'd0);
    chk("t2_busy_idle", 32'(busy12), 32'd0);
    @(negedge clk);
    chk("t5_start_in_done_ignored", 32'(busy12), 32'd0);
    chk("t5_addr_idle", 32'(addr12), 32'd0);
    chk("t2_ap_held", ap12, 32'd0);

    // One round, all S zero
    a1 = 32'h12345678; b1 = 32'h0; start1 = 1'b1; cyc = 0;
    do begin @(negedge clk); start1 = 1'b0; cyc++; end while (!done1 && cyc < 20);
    chk("t3_done", 32'(done1), 32'd1);
    chk("t3_latency", 32'(cyc), 32'd3);
`ifdef DECIPHER_ROT_EN
    chk("t3_ap", ap1, 32'h26622E6A);
`else
    chk("t3_ap", ap1, 32'h0);
`endif
    chk("t3_bp", bp1, 32'h12345678);

    // Wrap-around in the un-whitening subtract
    s1[0] = 32'hFFFFFFFF; s1[1] = 32'hFFFFFFFF;
    a1 = 32'h0; b1 = 32'h0; start1 = 1'b1; cyc = 0;
    repeat (2) @(negedge clk);
    do begin @(negedge clk); start1 = 1'b0; cyc++; end while (!done1 && cyc < 20);
    chk("t4_done", 32'(done1), 32'd1);
    chk("t4_ap", ap1, 32'h1);
    chk("t4_bp", bp1, 32'h1);

    // Random keys and blocks, start held high back-to-back
    for (int k = 0; k < 26; k++) s12[k] = $urandom();
    pa = $urandom(); pb = $urandom();
    enc12(pa, pb, ca, cb);
    exp_a = pa; exp_b = pb; a12 = ca; b12 = cb;
    start12 = 1'b1;
    for (int blk = 0; blk < 100; blk++) begin
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!done12 && cyc < 40);
      chk($sformatf("t6_done_b%0d", blk), 32'(done12), 32'd1);
      chk($sformatf("t6_ap_b%0d", blk), ap12, exp_a);
      chk($sformatf("t6_bp_b%0d", blk), bp12, exp_b);
      if (blk > 0) chk($sformatf("t6_period_b%0d", blk), 32'(cyc), 32'd15);
      for (int k = 0; k < 26; k++) s12[k] = $urandom();
      pa = $urandom(); pb = $urandom();
      enc12(pa, pb, ca, cb);
      exp_a = pa; exp_b = pb; a12 = ca; b12 = cb;
    end
    start12 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_idle_after", 32'(busy12), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
